// File: rtl/dm_responder.sv
// Data-memory responder for the CPU DM port: zero-latency reads, a clear FSM
// that zeroes storage after reset, sticky error flags and saturating counters.
//
// state | meaning
// CLEAR | zeroing mem[idx] one word per cycle; CPU requests rejected
// READY | storage cleared; legal CPU requests served
module dm_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DM_en,
    input  logic        DM_write,
    input  logic [31:0] DM_address,
    input  logic [31:0] DM_in,
    output logic [31:0] DM_out,
    output logic        init_done,
    output logic        err_misaligned,
    output logic        err_range,
    output logic        err_busy,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   last_rd;

    logic [AW-1:0] word_idx;
    logic          misaligned;
    logic          out_of_range;
    logic          ready;
    logic          legal;
    logic          legal_rd;
    logic          legal_wr;
    logic          illegal_rd;
    logic [31:0]   rd_data;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    assign word_idx     = DM_address[AW+1:2];
    assign misaligned   = DM_address[1:0] != 2'b00;
    assign out_of_range = (DM_address >> (AW + 2)) != 32'd0;
    assign ready        = state == READY;
    assign legal        = DM_en && ready && !misaligned && !out_of_range;
    assign legal_rd     = legal && !DM_write;
    assign legal_wr     = legal && DM_write;
    assign illegal_rd   = DM_en && !DM_write && !legal;
    assign rd_data      = mem[word_idx];
    assign init_done    = ready;

    always_comb begin
        DM_out = last_rd;
        if (legal_rd)
            DM_out = rd_data;
        else if (illegal_rd)
            DM_out = 32'd0;
    end

    // Single write port shared by the clear sweep and the CPU; CPU writes
    // are never legal during CLEAR, so the two cannot collide.
    assign mem_we    = !rst && (state == CLEAR || legal_wr);
    assign mem_waddr = (state == CLEAR) ? idx : word_idx;
    assign mem_wdata = (state == CLEAR) ? 32'd0 : DM_in;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= CLEAR;
            idx            <= '0;
            last_rd        <= 32'd0;
            err_misaligned <= 1'b0;
            err_range      <= 1'b0;
            err_busy       <= 1'b0;
            rd_cnt         <= 16'd0;
            wr_cnt         <= 16'd0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == AW'(DEPTH - 1))
                        state <= READY;
                end
                READY: state <= READY;
                default: state <= CLEAR;
            endcase

            if (DM_en) begin
                if (misaligned)
                    err_misaligned <= 1'b1;
                if (out_of_range)
                    err_range <= 1'b1;
                if (!ready)
                    err_busy <= 1'b1;
            end

            if (legal_rd) begin
                last_rd <= rd_data;
                if (rd_cnt != 16'hFFFF)
                    rd_cnt <= rd_cnt + 16'd1;
            end

            if (legal_wr && wr_cnt != 16'hFFFF)
                wr_cnt <= wr_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Randomized and directed bench for dm_responder (DEPTH = 16) against a
// cycle-level behavioural model of the memory, clear period and error rules.
module tb_dm_responder;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        DM_en;
    logic        DM_write;
    logic [31:0] DM_address;
    logic [31:0] DM_in;
    logic [31:0] DM_out;
    logic        init_done;
    logic        err_misaligned;
    logic        err_range;
    logic        err_busy;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    dm_responder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .DM_en         (DM_en),
        .DM_write      (DM_write),
        .DM_address    (DM_address),
        .DM_in         (DM_in),
        .DM_out        (DM_out),
        .init_done     (init_done),
        .err_misaligned(err_misaligned),
        .err_range     (err_range),
        .err_busy      (err_busy),
        .rd_cnt        (rd_cnt),
        .wr_cnt        (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: clear progress as a count of post-reset cycles.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_last;
    int          m_clr;
    bit          m_mis, m_rng, m_busy;
    int          m_rd, m_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_legal(input logic [31:0] a);
        return (m_clr >= DEPTH) && (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] m_out();
        if (DM_en && !DM_write)
            return m_legal(DM_address) ? m_mem[DM_address / 4] : 32'd0;
        return m_last;
    endfunction

    task automatic m_edge();
        if (rst) begin
            m_clr  = 0;
            m_last = 0;
            m_mis  = 0;
            m_rng  = 0;
            m_busy = 0;
            m_rd   = 0;
            m_wr   = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else begin
            if (DM_en) begin
                if (DM_address % 4 != 0) m_mis = 1;
                if (DM_address >= DEPTH * 4) m_rng = 1;
                if (m_clr < DEPTH) m_busy = 1;
                if (m_legal(DM_address)) begin
                    if (DM_write) begin
                        m_mem[DM_address / 4] = DM_in;
                        if (m_wr < 65535) m_wr++;
                    end else begin
                        m_last = m_mem[DM_address / 4];
                        if (m_rd < 65535) m_rd++;
                    end
                end
            end
            if (m_clr < DEPTH) m_clr++;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = r; DM_en = en; DM_write = wr; DM_address = a; DM_in = d;
        #1;
        if (!r) chk("dm_out", DM_out, m_out());
        @(posedge clk);
        #1;
        m_edge();
        chk("init_done", {31'd0, init_done}, {31'd0, m_clr >= DEPTH});
        chk("err_misaligned", {31'd0, err_misaligned}, {31'd0, m_mis});
        chk("err_range", {31'd0, err_range}, {31'd0, m_rng});
        chk("err_busy", {31'd0, err_busy}, {31'd0, m_busy});
        chk("rd_cnt", {16'd0, rd_cnt}, m_rd);
        chk("wr_cnt", {16'd0, wr_cnt}, m_wr);
        if (!rst && !DM_en) chk("dm_out_idle", DM_out, m_last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(0, 1, 0, a, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d);
    endtask

    logic [31:0] addr;
    int          sel;

    initial begin
        rst = 1; DM_en = 0; DM_write = 0; DM_address = 0; DM_in = 0;
        m_clr = 0; m_last = 0; m_mis = 0; m_rng = 0; m_busy = 0; m_rd = 0; m_wr = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        // 1: reset, clear period, every word reads zero
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_dm_out", DM_out, 32'd0);
        idle(DEPTH - 1);
        chk("init_low_at_15", {31'd0, init_done}, 32'd0);
        idle(1);
        chk("init_high_at_16", {31'd0, init_done}, 32'd1);
        for (int i = 0; i < DEPTH; i++) rd(i * 4);

        // 2: write then read back, output holds with DM_en low
        wr(32'h8, 32'hDEADBEEF);
        rd(32'h8);
        chk("rd_back", DM_out, 32'hDEADBEEF);
        idle(3);
        chk("hold_last", DM_out, 32'hDEADBEEF);

        // 3: illegal writes dropped, illegal reads return 0
        wr(32'h6, 32'h12345678);
        wr(32'h40, 32'h12345678);
        wr(32'h46, 32'h12345678);
        rd(32'h4);
        chk("word1_zero", DM_out, 32'd0);
        rd(32'h6);
        rd(32'h40);
        rd(32'h46);
        chk("err_both", {30'd0, err_misaligned, err_range}, 32'd3);

        // 4: write during clear flags busy and is dropped
        step(1, 0, 0, 0, 0);
        idle(3);
        wr(32'hC, 32'hCAFEF00D);
        chk("busy_set", {31'd0, err_busy}, 32'd1);
        idle(DEPTH);
        rd(32'hC);
        chk("busy_word_zero", DM_out, 32'd0);

        // 5: reset mid-clear and after READY wipes contents
        wr(32'h14, 32'h55AA55AA);
        step(1, 0, 0, 0, 0);
        idle(5);
        step(1, 0, 0, 0, 0);
        idle(DEPTH);
        step(1, 0, 0, 0, 0);
        idle(DEPTH);
        rd(32'h14);
        chk("word5_wiped", DM_out, 32'd0);

        // random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel == 0) begin
                step(1, 0, 0, 0, 0);
            end else begin
                case ($urandom_range(0, 9))
                    0: addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
                    1: addr = $urandom | 32'h40;
                    default: addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                endcase
                step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), addr, $urandom);
            end
        end

        // 6: read counter saturation
        idle(DEPTH);
        for (int n = 0; n < 65540; n++) rd({26'd0, 4'($urandom_range(0, 15)), 2'b00});
        chk("rd_sat", {16'd0, rd_cnt}, 32'h0000FFFF);
        rd(32'h0);
        chk("rd_sat_hold", {16'd0, rd_cnt}, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
